// File: rtl/unary_mac_pkg.sv
// Shared types and width helper for the unary multiply-accumulate datapath.
package unary_mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Largest product is 2^(2*bin_bits); summing num_terms of them needs clog2 more bits plus one.
    function automatic int acc_bits_f(input int bin_bits, input int num_terms);
        return 2 * bin_bits + $clog2(num_terms) + 1;
    endfunction

endpackage

// File: rtl/unary_term_detector.sv
// Finds the end of each unary product: a falling run, or a zero-product flag edge on an idle line.
module unary_term_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic in_unary,
    input  logic in_zero,
    output logic boundary
);

    logic prev_unary;
    logic prev_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_unary <= 1'b0;
            prev_zero  <= 1'b0;
        end else if (clear) begin
            prev_unary <= 1'b0;
            prev_zero  <= 1'b0;
        end else begin
            prev_unary <= in_unary;
            prev_zero  <= in_zero;
        end
    end

    // OR-ing the two causes makes a run end coincident with a zero edge count once.
    assign boundary = (prev_unary & ~in_unary)
                    | (in_zero & ~prev_zero & ~in_unary & ~prev_unary);

endmodule

// File: rtl/unary_shift_accumulator.sv
// Sums NUM_TERMS serial unary products into a binary result held until downstream accepts it.
module unary_shift_accumulator
    import unary_mac_pkg::*;
#(
    parameter int BIN_BITS  = 4,
    parameter int NUM_TERMS = 4,
    localparam int ACC_BITS = acc_bits_f(BIN_BITS, NUM_TERMS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_unary,
    input  logic                in_zero,
    input  logic                clear,
    input  logic                acc_ready,
    output logic [ACC_BITS-1:0] acc_out,
    output logic                acc_valid,
    output logic                overrun,
    output logic                sat
);

    localparam int TERM_W = $clog2(NUM_TERMS + 1);
    localparam logic [ACC_BITS-1:0] ACC_MAX  = {ACC_BITS{1'b1}};
    localparam logic [TERM_W-1:0]   LAST_IDX = TERM_W'(NUM_TERMS - 1);

    acc_state_e          state_q, state_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [TERM_W-1:0]   term_q, term_d;
    logic                ovr_q, ovr_d;
    logic                sat_q, sat_d;
    logic                boundary;

    unary_term_detector u_det (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .in_unary (in_unary),
        .in_zero  (in_zero),
        .boundary (boundary)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            term_q  <= '0;
            ovr_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            term_q  <= term_d;
            ovr_q   <= ovr_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        term_d  = term_q;
        ovr_d   = ovr_q;
        sat_d   = sat_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            term_d  = '0;
            ovr_d   = 1'b0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_unary) begin
                        if (acc_q == ACC_MAX) sat_d = 1'b1;
                        else                  acc_d = acc_q + 1'b1;
                    end
                    // A boundary always has in_unary low, so it never races the increment.
                    if (boundary) begin
                        term_d = term_q + 1'b1;
                        if (term_q == LAST_IDX) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (in_unary) ovr_d = 1'b1;
                    if (acc_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        term_d  = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = (state_q == HOLD);
    assign overrun   = ovr_q;
    assign sat       = sat_q;

endmodule

// File: doc/unary_shift_accumulator.md
UNARY_SHIFT_ACCUMULATOR -- requirements
Module: unary_shift_accumulator

Interface
REQ-001 SHALL have parameter BIN_BITS, default 4: operand width in binary; largest single unary product is 2^(2*BIN_BITS) pulses.
REQ-002 SHALL have parameter NUM_TERMS, default 4: number of products summed per result.
REQ-003 SHALL derive localparam ACC_BITS = 2*BIN_BITS + clog2(NUM_TERMS) + 1.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_unary  input  1  serial unary product stream from the upstream multiplier; one count per high cycle.
REQ-007 in_zero  input  1  upstream zero-product indicator, level signal.
REQ-008 clear  input  1  synchronous flush of accumulation.
REQ-009 acc_ready  input  1  downstream accepts the result.
REQ-010 acc_out  output  ACC_BITS  accumulated binary sum.
REQ-011 acc_valid  output  1  acc_out holds a complete NUM_TERMS sum.
REQ-012 overrun  output  1  sticky: in_unary was high while the result was held.
REQ-013 sat  output  1  sticky: accumulator saturated.

Function
REQ-014 SHALL implement states ACCUM and HOLD; reset state ACCUM.
REQ-015 In ACCUM, each cycle with in_unary=1 SHALL add 1 to the accumulator, saturating at 2^ACC_BITS-1 and setting sat.
REQ-016 SHALL register in_unary (prev_unary) and in_zero (prev_zero) for edge detection.
REQ-017 A term boundary SHALL occur when prev_unary=1 and in_unary=0 (end of run), or when there is an in_zero rising edge while in_unary=0 and prev_unary=0 (zero product).
REQ-018 Coincident run-end and in_zero rising edge SHALL count as one boundary.
REQ-019 Each boundary in ACCUM SHALL increment term_cnt (width clog2(NUM_TERMS+1)).
REQ-020 On the boundary that makes term_cnt equal NUM_TERMS, SHALL enter HOLD; acc_valid=1 the following cycle.
REQ-021 acc_out SHALL equal the accumulator at all times and SHALL be stable while acc_valid=1.
REQ-022 In HOLD, SHALL keep acc_valid=1 until acc_ready=1.
REQ-023 On acc_valid=1 and acc_ready=1, SHALL zero the accumulator and term_cnt and return to ACCUM; acc_valid=0 next cycle.
REQ-024 In HOLD, including the transfer cycle, in_unary=1 SHALL NOT add to the accumulator and SHALL set overrun.
REQ-025 In HOLD, boundaries SHALL be ignored.
REQ-026 acc_ready while acc_valid=0 SHALL have no effect.
REQ-027 clear=1 SHALL take priority over all other events: next cycle ACCUM, accumulator=0, term_cnt=0, acc_valid=0, overrun=0, sat=0, prev registers=0.
REQ-028 sat and overrun SHALL clear only by clear or reset, not by transfer.

Reset
REQ-029 reset_n=0 SHALL immediately force state=ACCUM, accumulator=0, term_cnt=0, prev_unary=0, prev_zero=0, acc_out=0, acc_valid=0, overrun=0, sat=0.
REQ-030 Reset mid-accumulation or mid-HOLD SHALL discard the partial sum; the first boundary after release counts as term 1.

Structure
REQ-031 State enum and an ACC_BITS helper function SHALL live in shared package unary_mac_pkg.
REQ-032 Boundary detection (REQ-016 to REQ-018) SHALL be sub-module unary_term_detector: inputs clk, reset_n, clear, in_unary, in_zero; output boundary.

Verification (BIN_BITS=4, NUM_TERMS=4, ACC_BITS=11)
REQ-033 Runs of 3, 5, 0 (in_zero pulse) and 7 high cycles, each separated by a 1-cycle gap, with acc_ready=1 -> acc_valid one cycle after the 4th run ends, acc_out=15, then acc_valid=0 and acc_out=0.
REQ-034 Same stimulus with acc_ready=0 for 10 cycles and in_unary toggling during HOLD -> acc_out stays 15, overrun=1, transfer on acc_ready, overrun remains 1.
REQ-035 clear asserted after 2 terms (sum 8) -> acc_out=0, term_cnt=0; then 4 runs of 1 -> acc_out=4.
REQ-036 4 runs of 600 cycles -> acc_out=2047, sat=1.
REQ-037 reset_n pulsed low mid-run after 2 terms -> all outputs 0 asynchronously; next 4 runs of 2 -> acc_out=8.
REQ-038 in_zero held high across 3 cycles plus a coincident run-end -> exactly one term counted per rising edge/run-end.
